// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes and
// datapath mux select values, used by the controller, the datapath and the bench.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_BRANCH   = 4'd6,
    S_JUMP     = 4'd7,
    S_JAL      = 4'd8,
    S_MEM_ADDR = 4'd9,
    S_MEM_RD   = 4'd10,
    S_MEM_WB   = 4'd11,
    S_MEM_WR   = 4'd12,
    S_TRAP     = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  localparam logic [1:0] ASB_RT     = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  // Immediate ALU group addi..lui (0x08-0x0F): the only I-types treated as defined.
  function automatic logic is_itype(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: clears on clr_i, counts on en_i, and flags the cycle whose
// wait would be the LIMIT-th consecutive one.
module mc_wait_timer #(
  parameter int TW    = 8,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  // cnt_q holds the waits already seen, so the current wait is number cnt_q+1.
  assign expire_o = en_i && (cnt_q == TW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multi-cycle MIPS datapath with memory stall/timeout.
// Define MULTICYCLE_CTRL_TRAP_EN to trap undefined opcodes instead of running them as I-type.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_byte,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem2reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       epc_write,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state_o
);

  state_e state_q;
  logic   in_mem_state;
  logic   wait_expire;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Memory states only leave on ready, so clearing on ready (or outside them)
  // is the same as clearing on entry.
  mc_wait_timer #(
    .TW    (TW),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_mem_state || mem_ready),
    .en_i     (in_mem_state && !mem_ready),
    .expire_o (wait_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)        state_q <= S_DECODE;
          else if (wait_expire) state_q <= S_FAULT;
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:                  state_q <= S_EXEC_R;
            OP_J:                      state_q <= S_JUMP;
            OP_JAL:                    state_q <= S_JAL;
            OP_BEQ, OP_BNE:            state_q <= S_BRANCH;
            OP_LB, OP_LW, OP_SB, OP_SW: state_q <= S_MEM_ADDR;
            default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
              state_q <= is_itype(opcode) ? S_EXEC_I : S_TRAP;
`else
              state_q <= S_EXEC_I;
`endif
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_ALU_WB;
        S_MEM_ADDR: begin
          if (opcode == OP_SB || opcode == OP_SW) state_q <= S_MEM_WR;
          else                                    state_q <= S_MEM_RD;
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            state_q <= (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
          end else if (wait_expire) begin
            state_q <= S_FAULT;
          end
        end
        S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_MEM_WB: state_q <= S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_TRAP:   state_q <= S_FETCH;
`endif
        S_FAULT:  state_q <= S_FAULT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_byte      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = RDST_RT;
    mem2reg       = M2R_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_RT;
    alu_op        = ALUOP_ADD;
    epc_write     = 1'b0;
    instr_done    = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = ASB_IMM_SH;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        alu_op    = ALUOP_ITYPE;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RDST_RA;
        mem2reg    = M2R_PC;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        mem_byte = (opcode == OP_LB);
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem2reg    = M2R_MDR;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        mem_byte   = (opcode == OP_SB);
        instr_done = mem_ready;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP: begin
        epc_write  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = PCSRC_TRAP;
        instr_done = 1'b1;
      end
`endif
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-by-cycle vector table plus
// hand-written timeout, trap and mid-access reset sequences.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       mem_byte, reg_write, alu_src_a, epc_write, instr_done, fault;
  logic [1:0] pc_source, reg_dst, mem2reg, alu_src_b, alu_op;
  logic [3:0] state_o;
  logic [22:0] ctl;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte(mem_byte), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem2reg(mem2reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .epc_write(epc_write), .instr_done(instr_done), .fault(fault), .state_o(state_o)
  );

  // Field order: {ir pcw pcwc bne}_{pc_source}_{iord rd wr byte}_{reg_write}_{reg_dst}_{mem2reg}_{src_a}_{src_b}_{alu_op}_{epc done fault}
  assign ctl = {ir_write, pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                mem_write, mem_byte, reg_write, reg_dst, mem2reg, alu_src_a, alu_src_b,
                alu_op, epc_write, instr_done, fault};

  localparam logic [22:0] C_ZERO       = 23'b0000_00_0000_0_00_00_0_00_00_000;
  localparam logic [22:0] C_FETCH_RDY  = 23'b1100_00_0100_0_00_00_0_01_00_000;
  localparam logic [22:0] C_FETCH_WAIT = 23'b0000_00_0100_0_00_00_0_01_00_000;
  localparam logic [22:0] C_DECODE     = 23'b0000_00_0000_0_00_00_0_11_00_000;
  localparam logic [22:0] C_EXEC_R     = 23'b0000_00_0000_0_00_00_1_00_10_000;
  localparam logic [22:0] C_EXEC_I     = 23'b0000_00_0000_0_00_00_1_10_11_000;
  localparam logic [22:0] C_WB_R       = 23'b0000_00_0000_1_01_00_0_00_00_010;
  localparam logic [22:0] C_WB_I       = 23'b0000_00_0000_1_00_00_0_00_00_010;
  localparam logic [22:0] C_BNE        = 23'b0011_01_0000_0_00_00_1_00_01_010;
  localparam logic [22:0] C_BEQ        = 23'b0010_01_0000_0_00_00_1_00_01_010;
  localparam logic [22:0] C_JUMP       = 23'b0100_10_0000_0_00_00_0_00_00_010;
  localparam logic [22:0] C_JAL        = 23'b0100_10_0000_1_10_10_0_00_00_010;
  localparam logic [22:0] C_MEM_ADDR   = 23'b0000_00_0000_0_00_00_1_10_00_000;
  localparam logic [22:0] C_RD_LB      = 23'b0000_00_1101_0_00_00_0_00_00_000;
  localparam logic [22:0] C_RD_LW      = 23'b0000_00_1100_0_00_00_0_00_00_000;
  localparam logic [22:0] C_MEM_WB     = 23'b0000_00_0000_1_00_01_0_00_00_010;
  localparam logic [22:0] C_WR_SW_WAIT = 23'b0000_00_1010_0_00_00_0_00_00_000;
  localparam logic [22:0] C_WR_SW_DONE = 23'b0000_00_1010_0_00_00_0_00_00_010;
  localparam logic [22:0] C_WR_SB_DONE = 23'b0000_00_1011_0_00_00_0_00_00_010;
  localparam logic [22:0] C_FAULT      = 23'b0000_00_0000_0_00_00_0_00_00_001;
  localparam logic [22:0] C_TRAP       = 23'b0100_11_0000_0_00_00_0_00_00_110;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [22:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input state_e st, input logic [22:0] c);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp_st, input logic [22:0] exp_ctl);
    n_total++;
    if (state_o === exp_st && ctl === exp_ctl) begin
      n_pass++;
    end else begin
      $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, state_o, ctl, exp_st, exp_ctl);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic step(input string name, input logic r, input logic [5:0] op, input logic rdy,
                      input state_e st, input logic [22:0] c);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = rdy;
    @(negedge clk);
    check(name, st, c);
  endtask

  task automatic do_reset(input logic [5:0] op);
    step("reset_held", 1'b1, op, 1'b1, S_IDLE, C_ZERO);
    step("reset_release_idle", 1'b0, op, 1'b1, S_IDLE, C_ZERO);
  endtask

  initial begin
    // Reset then R-type; mem_ready=0 outside memory states must be ignored.
    add(1, 6'h00, 1, S_IDLE,     C_ZERO);
    add(0, 6'h00, 1, S_IDLE,     C_ZERO);
    add(0, 6'h00, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h00, 0, S_DECODE,   C_DECODE);
    add(0, 6'h00, 0, S_EXEC_R,   C_EXEC_R);
    add(0, 6'h00, 0, S_ALU_WB,   C_WB_R);
    // LB with 3 wait cycles
    add(0, 6'h20, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h20, 1, S_DECODE,   C_DECODE);
    add(0, 6'h20, 1, S_MEM_ADDR, C_MEM_ADDR);
    add(0, 6'h20, 0, S_MEM_RD,   C_RD_LB);
    add(0, 6'h20, 0, S_MEM_RD,   C_RD_LB);
    add(0, 6'h20, 0, S_MEM_RD,   C_RD_LB);
    add(0, 6'h20, 1, S_MEM_RD,   C_RD_LB);
    add(0, 6'h20, 0, S_MEM_WB,   C_MEM_WB);
    // bne
    add(0, 6'h05, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h05, 1, S_DECODE,   C_DECODE);
    add(0, 6'h05, 1, S_BRANCH,   C_BNE);
    // beq with one fetch wait
    add(0, 6'h04, 0, S_FETCH,    C_FETCH_WAIT);
    add(0, 6'h04, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h04, 1, S_DECODE,   C_DECODE);
    add(0, 6'h04, 1, S_BRANCH,   C_BEQ);
    // jal, j
    add(0, 6'h03, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h03, 1, S_DECODE,   C_DECODE);
    add(0, 6'h03, 1, S_JAL,      C_JAL);
    add(0, 6'h02, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h02, 1, S_DECODE,   C_DECODE);
    add(0, 6'h02, 1, S_JUMP,     C_JUMP);
    // addi
    add(0, 6'h08, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h08, 1, S_DECODE,   C_DECODE);
    add(0, 6'h08, 1, S_EXEC_I,   C_EXEC_I);
    add(0, 6'h08, 1, S_ALU_WB,   C_WB_I);
    // sw with one wait
    add(0, 6'h2B, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h2B, 1, S_DECODE,   C_DECODE);
    add(0, 6'h2B, 1, S_MEM_ADDR, C_MEM_ADDR);
    add(0, 6'h2B, 0, S_MEM_WR,   C_WR_SW_WAIT);
    add(0, 6'h2B, 1, S_MEM_WR,   C_WR_SW_DONE);
    // sb
    add(0, 6'h28, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h28, 1, S_DECODE,   C_DECODE);
    add(0, 6'h28, 1, S_MEM_ADDR, C_MEM_ADDR);
    add(0, 6'h28, 1, S_MEM_WR,   C_WR_SB_DONE);
    // lw
    add(0, 6'h23, 1, S_FETCH,    C_FETCH_RDY);
    add(0, 6'h23, 1, S_DECODE,   C_DECODE);
    add(0, 6'h23, 1, S_MEM_ADDR, C_MEM_ADDR);
    add(0, 6'h23, 1, S_MEM_RD,   C_RD_LW);
    add(0, 6'h23, 1, S_MEM_WB,   C_MEM_WB);
    add(0, 6'h00, 0, S_FETCH,    C_FETCH_WAIT);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
           state_e'(vecs[i].st), vecs[i].ctl);
    end

    // Timeout: 15 fetch waits, then sticky FAULT regardless of mem_ready.
    do_reset(6'h00);
    for (int i = 1; i <= 15; i++) step($sformatf("timeout_wait%0d", i), 1'b0, 6'h00, 1'b0, S_FETCH, C_FETCH_WAIT);
    for (int i = 0; i < 3; i++) step($sformatf("fault_sticky%0d", i), 1'b0, 6'h00, 1'b1, S_FAULT, C_FAULT);
    do_reset(6'h00);
    step("after_fault_fetch", 1'b0, 6'h00, 1'b0, S_FETCH, C_FETCH_WAIT);

    // Ready on the 15th wait cycle wins over the timeout.
    do_reset(6'h00);
    for (int i = 1; i <= 14; i++) step($sformatf("near_wait%0d", i), 1'b0, 6'h00, 1'b0, S_FETCH, C_FETCH_WAIT);
    step("near_ready15", 1'b0, 6'h00, 1'b1, S_FETCH, C_FETCH_RDY);
    step("near_decode", 1'b0, 6'h00, 1'b0, S_DECODE, C_DECODE);

    // Undefined opcode 0x3F.
    do_reset(6'h3F);
    step("undef_fetch", 1'b0, 6'h3F, 1'b1, S_FETCH, C_FETCH_RDY);
    step("undef_decode", 1'b0, 6'h3F, 1'b1, S_DECODE, C_DECODE);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    step("undef_trap", 1'b0, 6'h3F, 1'b1, S_TRAP, C_TRAP);
    step("trap_to_fetch", 1'b0, 6'h3F, 1'b1, S_FETCH, C_FETCH_RDY);
`else
    step("undef_exec_i", 1'b0, 6'h3F, 1'b1, S_EXEC_I, C_EXEC_I);
    step("undef_wb", 1'b0, 6'h3F, 1'b1, S_ALU_WB, C_WB_I);
`endif

    // Reset mid-write: strobe must drop before the next clock edge.
    do_reset(6'h2B);
    step("mw_fetch", 1'b0, 6'h2B, 1'b1, S_FETCH, C_FETCH_RDY);
    step("mw_decode", 1'b0, 6'h2B, 1'b1, S_DECODE, C_DECODE);
    step("mw_addr", 1'b0, 6'h2B, 1'b0, S_MEM_ADDR, C_MEM_ADDR);
    step("mw_wait", 1'b0, 6'h2B, 1'b0, S_MEM_WR, C_WR_SW_WAIT);
    #2;
    rst = 1'b1;
    #1;
    check("mw_async_reset", S_IDLE, C_ZERO);
    step("mw_release", 1'b0, 6'h2B, 1'b1, S_IDLE, C_ZERO);
    step("mw_refetch", 1'b0, 6'h2B, 1'b1, S_FETCH, C_FETCH_RDY);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
